// File: rtl/upscale2x_seq_if.sv
// rtl/upscale2x_seq_if.sv - control, input-stream and output-stream signals of the 2x upscaler sequencer
interface upscale2x_seq_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 7
);
  logic              start;
  logic [CNT_W-1:0]  cfg_width;
  logic [CNT_W-1:0]  cfg_height;
  logic              busy;
  logic              done;
  logic              err;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              m_eof;

  modport slave (
    input  start, cfg_width, cfg_height, s_valid, s_data, m_ready,
    output busy, done, err, s_ready, m_valid, m_data, m_last, m_eof
  );

  modport master (
    output start, cfg_width, cfg_height, s_valid, s_data, m_ready,
    input  busy, done, err, s_ready, m_valid, m_data, m_last, m_eof
  );
endinterface

// File: rtl/upscale2x_seq.sv
// rtl/upscale2x_seq.sv - 2x nearest-neighbour upscaler sequencer with a one-row register line buffer
module upscale2x_seq #(
  parameter int DATA_W = 8,
  parameter int MAX_W  = 64,
  parameter int CNT_W  = 7
) (
  input  logic          clk,
  input  logic          rst,
  upscale2x_seq_if.slave io
);
  localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_EMIT0, S_EMIT1, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  w_q, w_d, h_q, h_d;
  logic [CNT_W-1:0]  col_q, col_d, row_q, row_d;
  logic              dup_q, dup_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] line_q [MAX_W];
  logic [DATA_W-1:0] line_d [MAX_W];

  logic [AW-1:0] col_idx;
  logic          col_end;
  logic          row_end;
  logic          emit;
  logic          cfg_ok;
  logic          m_last;

  // col never exceeds W-1 <= MAX_W-1, so the low bits always address a real entry
  assign col_idx = col_q[AW-1:0];
  assign col_end = (col_q == w_q - CNT_W'(1));
  assign row_end = (row_q == h_q - CNT_W'(1));
  assign emit    = (state_q == S_EMIT0) || (state_q == S_EMIT1);
  assign cfg_ok  = (io.cfg_width != '0) && (io.cfg_width <= CNT_W'(MAX_W)) &&
                   (io.cfg_height != '0);
  assign m_last  = emit && dup_q && col_end;

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    h_d     = h_q;
    col_d   = col_q;
    row_d   = row_q;
    dup_d   = dup_q;
    err_d   = 1'b0;
    line_d  = line_q;
    case (state_q)
      S_IDLE: begin
        if (io.start) begin
          if (cfg_ok) begin
            w_d     = io.cfg_width;
            h_d     = io.cfg_height;
            col_d   = '0;
            row_d   = '0;
            dup_d   = 1'b0;
            state_d = S_FILL;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_FILL: begin
        if (io.s_valid) begin
          line_d[col_idx] = io.s_data;
          if (col_end) begin
            col_d   = '0;
            state_d = S_EMIT0;
          end else begin
            col_d = col_q + CNT_W'(1);
          end
        end
      end
      S_EMIT0, S_EMIT1: begin
        if (io.m_ready) begin
          dup_d = ~dup_q;
          // the second copy of a pixel advances the column
          if (dup_q) begin
            if (col_end) begin
              col_d = '0;
              if (state_q == S_EMIT0) begin
                state_d = S_EMIT1;
              end else begin
                row_d   = row_q + CNT_W'(1);
                state_d = row_end ? S_DONE : S_FILL;
              end
            end else begin
              col_d = col_q + CNT_W'(1);
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      w_q     <= '0;
      h_q     <= '0;
      col_q   <= '0;
      row_q   <= '0;
      dup_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      h_q     <= h_d;
      col_q   <= col_d;
      row_q   <= row_d;
      dup_q   <= dup_d;
      err_q   <= err_d;
    end
  end

  // line buffer contents are intentionally left out of reset
  always_ff @(posedge clk) begin
    line_q <= line_d;
  end

  assign io.busy    = (state_q != S_IDLE) && (state_q != S_DONE);
  assign io.done    = (state_q == S_DONE);
  assign io.err     = err_q;
  assign io.s_ready = (state_q == S_FILL);
  assign io.m_valid = emit;
  assign io.m_data  = emit ? line_q[col_idx] : '0;
  assign io.m_last  = m_last;
  assign io.m_eof   = m_last && (state_q == S_EMIT1) && row_end;
endmodule

// File: tb/tb_upscale2x_seq.sv
// tb/tb_upscale2x_seq.sv - self-checking bench for upscale2x_seq against a frame-level expected beat list
module tb_upscale2x_seq;
  localparam int DATA_W = 8;
  localparam int MAX_W  = 64;
  localparam int CNT_W  = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  upscale2x_seq_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) io();

  upscale2x_seq #(.DATA_W(DATA_W), .MAX_W(MAX_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [DATA_W-1:0] pix[$];
  int                done_cyc;
  int                last_hs_cyc;
  int                last_in_cyc;
  int                first_mv_cyc;
  int                beats;
  logic [DATA_W-1:0] last_data;

  task automatic idle_inputs();
    io.start      = 1'b0;
    io.cfg_width  = '0;
    io.cfg_height = '0;
    io.s_valid    = 1'b0;
    io.s_data     = '0;
    io.m_ready    = 1'b0;
  endtask

  task automatic fill_pix(input int n, input bit ramp, input int base);
    pix.delete();
    for (int i = 0; i < n; i++) pix.push_back(ramp ? DATA_W'(base + i) : DATA_W'($urandom));
  endtask

  // vmode: 0 always valid, 1 every third cycle, 2 random; rmode: 0 always ready, 1 pattern 1,0,0,1, 2 random
  task automatic run_frame(input int w, input int h, input int vmode, input int rmode,
                           input int rst_at, input bit repulse);
    logic [DATA_W+1:0] exp_q[$];
    logic [DATA_W+1:0] got, want, prev_out;
    int  cyc, in_idx, k, limit;
    bit  prev_stall, finished, pulsed, l;
    int  rpat[4];
    rpat = '{1, 0, 0, 1};
    for (int r = 0; r < h; r++)
      for (int rep = 0; rep < 2; rep++)
        for (int c = 0; c < w; c++)
          for (int d = 0; d < 2; d++) begin
            l = (c == w - 1) && (d == 1);
            exp_q.push_back({pix[r*w+c], l, l && (rep == 1) && (r == h - 1)});
          end
    done_cyc = -1; last_hs_cyc = -1; last_in_cyc = -1; first_mv_cyc = -1;
    beats = 0; last_data = '0;
    in_idx = 0; k = 0; prev_stall = 0; finished = 0; pulsed = 0; prev_out = '0;
    limit = 20 * w * h + 100;
    @(negedge clk);
    io.start = 1'b1; io.cfg_width = CNT_W'(w); io.cfg_height = CNT_W'(h);
    io.s_valid = 1'b0; io.m_ready = 1'b0;
    cyc = 0;
    while (!finished && cyc < limit) begin
      @(negedge clk);
      cyc++;
      io.start = 1'b0;
      if (io.done) begin
        done_cyc = cyc;
        n_cmp++;
        if (io.busy !== 1'b0) begin
          n_bad++; $display("FAIL done_busy: busy=%b required 0", io.busy);
        end
        @(negedge clk);
        n_cmp++;
        if (io.done !== 1'b0 || io.busy !== 1'b0) begin
          n_bad++; $display("FAIL done_pulse: done=%b busy=%b required 0 0", io.done, io.busy);
        end
        finished = 1;
      end else begin
        case (vmode)
          0:       io.s_valid = 1'b1;
          1:       io.s_valid = (cyc % 3 == 1);
          default: io.s_valid = $urandom_range(0, 1) == 1;
        endcase
        io.s_data = (in_idx < w * h) ? pix[in_idx] : DATA_W'($urandom);
        case (rmode)
          0:       io.m_ready = 1'b1;
          1:       io.m_ready = rpat[k % 4] == 1;
          default: io.m_ready = $urandom_range(0, 1) == 1;
        endcase
        if (io.m_valid) k++;
        if (rst_at > 0 && io.m_valid && beats == rst_at - 1) begin
          rst = 1'b1; io.m_ready = 1'b1;
          @(negedge clk);
          rst = 1'b0; io.s_valid = 1'b0; io.m_ready = 1'b0;
          n_cmp++;
          if (io.m_valid !== 1'b0 || io.busy !== 1'b0 || io.done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid: m_valid=%b busy=%b done=%b required 0 0 0",
                     io.m_valid, io.busy, io.done);
          end
          @(negedge clk);
          n_cmp++;
          if (io.done !== 1'b0 || io.m_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_mid_after: done=%b m_valid=%b required 0 0", io.done, io.m_valid);
          end
          idle_inputs();
          return;
        end
        got = {io.m_data, io.m_last, io.m_eof};
        if (prev_stall) begin
          n_cmp++;
          if (io.m_valid !== 1'b1 || got !== prev_out) begin
            n_bad++;
            $display("FAIL stall_hold: valid=%b out=%h required valid=1 out=%h", io.m_valid, got, prev_out);
          end
        end
        if (!io.m_valid) begin
          n_cmp++;
          if (io.m_data !== '0) begin
            n_bad++; $display("FAIL idle_data: m_data=%h required 0", io.m_data);
          end
        end else if (first_mv_cyc < 0) begin
          first_mv_cyc = cyc;
        end
        if (io.s_valid && io.s_ready) begin
          in_idx++;
          last_in_cyc = cyc;
        end
        if (io.m_valid && io.m_ready) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_bad++; $display("FAIL extra_beat: out=%h required no beat", got);
          end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
              n_bad++;
              $display("FAIL beat%0d: data/last/eof=%h/%b/%b required %h/%b/%b", beats,
                       got[DATA_W+1:2], got[1], got[0], want[DATA_W+1:2], want[1], want[0]);
            end
          end
          beats++;
          last_hs_cyc = cyc;
          last_data = io.m_data;
        end
        prev_stall = io.m_valid && !io.m_ready;
        prev_out = got;
        if (repulse && !pulsed && beats == 2 * w + 1) begin
          io.start = 1'b1; io.cfg_width = CNT_W'(1); io.cfg_height = CNT_W'(1);
          pulsed = 1;
        end
      end
    end
    n_cmp++;
    if (!finished) begin
      n_bad++; $display("FAIL timeout: no done within %0d cycles (beats=%0d)", limit, beats);
    end else if (exp_q.size() != 0 || in_idx != w * h) begin
      n_bad++;
      $display("FAIL frame_count: beats left=%0d inputs=%0d required 0 and %0d", exp_q.size(), in_idx, w * h);
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({io.busy, io.done, io.err, io.s_ready, io.m_valid, io.m_last, io.m_eof} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_flags: busy/done/err/s_ready/m_valid/m_last/m_eof=%b required 0000000",
               {io.busy, io.done, io.err, io.s_ready, io.m_valid, io.m_last, io.m_eof});
    end
    n_cmp++;
    if (io.m_data !== '0) begin
      n_bad++; $display("FAIL reset_data: m_data=%h required 0", io.m_data);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    fill_pix(6, 1, 'h10);
    run_frame(3, 2, 0, 0, 0, 0);
    n_cmp++;
    if (done_cyc != 31 || last_hs_cyc != 30 || beats != 24) begin
      n_bad++;
      $display("FAIL basic_timing: done=%0d last_hs=%0d beats=%0d required 31 30 24", done_cyc, last_hs_cyc, beats);
    end
  endtask

  task automatic test_backpressure();
    fill_pix(6, 1, 'h10);
    run_frame(3, 2, 0, 1, 0, 0);
    n_cmp++;
    if (beats != 24 || done_cyc <= 31) begin
      n_bad++; $display("FAIL backpressure: beats=%0d done=%0d required 24 and >31", beats, done_cyc);
    end
  endtask

  task automatic test_input_gaps();
    fill_pix(4, 0, 0);
    run_frame(4, 1, 1, 0, 0, 0);
    n_cmp++;
    if (last_in_cyc != 10 || first_mv_cyc != 11 || beats != 16) begin
      n_bad++;
      $display("FAIL input_gaps: last_in=%0d first_mv=%0d beats=%0d required 10 11 16",
               last_in_cyc, first_mv_cyc, beats);
    end
  endtask

  task automatic test_illegal();
    int ws[3];
    int hs[3];
    ws = '{0, MAX_W + 1, 2};
    hs = '{1, 1, 0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      io.start = 1'b1; io.cfg_width = CNT_W'(ws[i]); io.cfg_height = CNT_W'(hs[i]);
      @(negedge clk);
      io.start = 1'b0;
      n_cmp++;
      if (io.err !== 1'b1 || io.busy !== 1'b0) begin
        n_bad++; $display("FAIL illegal%0d_err: err=%b busy=%b required 1 0", i, io.err, io.busy);
      end
      @(negedge clk);
      n_cmp++;
      if (io.err !== 1'b0 || io.busy !== 1'b0) begin
        n_bad++; $display("FAIL illegal%0d_after: err=%b busy=%b required 0 0", i, io.err, io.busy);
      end
    end
    idle_inputs();
    fill_pix(1, 0, 0);
    run_frame(1, 1, 0, 0, 0, 0);
    n_cmp++;
    if (beats != 4 || done_cyc != 6) begin
      n_bad++; $display("FAIL w1_frame: beats=%0d done=%0d required 4 6", beats, done_cyc);
    end
  endtask

  task automatic test_reset_mid();
    fill_pix(8, 0, 0);
    run_frame(4, 2, 0, 0, 5, 0);
    n_cmp++;
    if (beats != 4) begin
      n_bad++; $display("FAIL reset_mid_beats: beats=%0d required 4", beats);
    end
    fill_pix(8, 0, 0);
    run_frame(4, 2, 0, 0, 0, 0);
    n_cmp++;
    if (done_cyc != 41 || beats != 32) begin
      n_bad++; $display("FAIL reset_recover: done=%0d beats=%0d required 41 32", done_cyc, beats);
    end
  endtask

  task automatic test_boundary();
    fill_pix(MAX_W, 0, 0);
    run_frame(MAX_W, 1, 0, 0, 0, 1);
    n_cmp++;
    if (beats != 4 * MAX_W || last_data !== pix[MAX_W-1] || done_cyc != 5 * MAX_W + 1) begin
      n_bad++;
      $display("FAIL max_width: beats=%0d last=%h done=%0d required %0d %h %0d",
               beats, last_data, done_cyc, 4 * MAX_W, pix[MAX_W-1], 5 * MAX_W + 1);
    end
  endtask

  task automatic test_random();
    int w, h;
    for (int i = 0; i < 4; i++) begin
      w = $urandom_range(1, 16);
      h = $urandom_range(1, 3);
      fill_pix(w * h, 0, 0);
      run_frame(w, h, 2, 2, 0, 0);
      n_cmp++;
      if (beats != 4 * w * h) begin
        n_bad++; $display("FAIL random%0d_beats: beats=%0d required %0d", i, beats, 4 * w * h);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_basic();
    test_backpressure();
    test_input_gaps();
    test_illegal();
    test_reset_mid();
    test_boundary();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
